instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter: WAIT_STATES, default 2; number of extra stall cycles per fetch (0..15).
REQ-002 Parameter: DEPTH_WORDS, default 256; number of 32-bit words in the array (power of 2).
REQ-003 Parameter: BASE_ADDR, default 32'hBFC00000; byte address of word 0.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: read  input  1  fetch request from the program-counter/fetch side; held high until accepted.
REQ-007 Port: address  input  32  byte address of the requested instruction.
REQ-008 Port: waitrequest  output  1  high = request not yet accepted; the initiator holds read and address.
REQ-009 Port: readdata  output  32  instruction word; valid in the cycle where read=1 and waitrequest=0.
REQ-010 Port: fault  output  1  qualified like readdata; high = address misaligned or out of range.
REQ-011 Port: load_en  input  1  preload write strobe.
REQ-012 Port: load_index  input  log2(DEPTH_WORDS)  preload word index.
REQ-013 Port: load_data  input  32  preload word.

Function
REQ-014 States: IDLE, WAIT, DONE.
REQ-015 IDLE with read=1: the block captures address, loads the wait counter with WAIT_STATES, and moves to WAIT if WAIT_STATES>0, else to DONE.
REQ-016 WAIT: the counter decrements each cycle; at count 1 with read=1 the block moves to DONE.
REQ-017 DONE: waitrequest=0; readdata/fault present the captured-address result; the transfer completes at this edge; next state IDLE.
REQ-018 waitrequest = NOT(state==DONE) at all times, so it is high in IDLE and WAIT regardless of read.
REQ-019 Latency: for read first high before edge n, the completing edge is n+WAIT_STATES+1; back-to-back fetches cost WAIT_STATES+2 cycles each.
REQ-020 Address changes after capture are ignored until the transfer completes.
REQ-021 read low in WAIT or DONE (abort): the block returns to IDLE at the next edge with no response and leaves readdata unchanged.
REQ-022 Word index = (captured address - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-023 Fault if address[1:0] != 0 or index >= DEPTH_WORDS (this includes address 32'h0, the halt address); in a fault case readdata = 32'h0 and fault = 1.
REQ-024 The array word is sampled on the edge entering DONE; readdata/fault are registered and hold their value until the next DONE entry.
REQ-025 load_en writes mem[load_index] <= load_data at posedge in any state.
REQ-026 A load to the same index on the edge that samples a fetch makes the fetch return the old word; the new word is visible from the next fetch.
REQ-027 The array has no reset; contents are undefined until loaded.

Reset
REQ-028 With reset=0: state=IDLE, counter=0, readdata=32'h0, fault=0, waitrequest=1, asynchronously and independent of clk.
REQ-029 Reset asserted in WAIT or DONE: the in-flight fetch is discarded and no response is issued after release.
REQ-030 After reset is released, the first read is accepted as in REQ-015 at the first posedge with reset=1.

Verification
REQ-031 WAIT_STATES=2; load index0=32'h3C011234; read addr 32'hBFC00000 held -> waitrequest low exactly 3 edges later, readdata=32'h3C011234, fault=0.
REQ-032 WAIT_STATES=0; two back-to-back reads of BFC00004, BFC00008 -> each completes 1 edge after acceptance, with correct words in order.
REQ-033 Read addr 32'h00000000, then 32'hBFC00002 -> fault=1 and readdata=0 for each; read of BFC003FC (index 255) -> fault=0.
REQ-034 Read low during WAIT, then a new read of BFC00010 -> no spurious completion; the new fetch returns mem[4].
REQ-035 reset=0 pulsed mid-WAIT -> waitrequest=1, readdata=0 immediately; no completion until a fresh read.
REQ-036 load_en to index 1 on the DONE-entry edge of a fetch to index 1 -> old word returned; the next fetch returns the new word.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: a preloadable word array behind a waitrequest-style fetch
// port, with a fixed number of stall cycles per fetch and a fault flag for bad addresses.
module instr_mem_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read,
    input  logic [31:0]                    address,
    output logic                           waitrequest,
    output logic [31:0]                    readdata,
    output logic                           fault,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
    input  logic [31:0]                    load_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        wreq_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] fetch_addr_d;
    logic        fetch_fault_d;
    logic [31:0] fetch_word_d;

    // Misaligned, or offset from the base (wrapping) lands outside the array.
    function automatic logic addr_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    // Result to be latched on the edge entering DONE; in IDLE the live address is captured.
    always_comb begin
        fetch_addr_d  = addr_q;
        fetch_fault_d = 1'b0;
        fetch_word_d  = 32'h0;
        if (state_q == S_IDLE) begin
            fetch_addr_d = address;
        end else begin
            fetch_addr_d = addr_q;
        end
        fetch_fault_d = addr_fault(fetch_addr_d);
        if (fetch_fault_d) begin
            fetch_word_d = 32'h0;
        end else begin
            fetch_word_d = mem_q[word_index(fetch_addr_d)];
        end
    end

    // Preload port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_index] <= load_data;
        end
    end

    // Fetch FSM with registered waitrequest/readdata/fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            wreq_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (read) begin
                        addr_q <= address;
                        cnt_q  <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state_q <= S_DONE;
                            wreq_q  <= 1'b0;
                            rdata_q <= fetch_word_d;
                            fault_q <= fetch_fault_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!read) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= S_DONE;
                        cnt_q   <= 4'd0;
                        wreq_q  <= 1'b0;
                        rdata_q <= fetch_word_d;
                        fault_q <= fetch_fault_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    wreq_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    wreq_q  <= 1'b1;
                end
            endcase
        end
    end

    assign waitrequest = wreq_q;
    assign readdata    = rdata_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (2 and 0 wait states) share stimulus via a
// select bit; a queue-based scoreboard is checked by a monitor on the falling clock edge.
module tb_instr_mem_responder;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read;
    logic        sel;
    logic [31:0] address;
    logic        load_en;
    logic [7:0]  load_index;
    logic [31:0] load_data;

    logic        read_a, read_b;
    logic        wr_a, wr_b, f_a, f_b;
    logic [31:0] rd_a, rd_b;
    logic        wr_s, f_s;
    logic [31:0] rd_s;

    logic [31:0] mem_m [256];
    logic [32:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    assign read_a = read & ~sel;
    assign read_b = read & sel;
    assign wr_s   = sel ? wr_b : wr_a;
    assign rd_s   = sel ? rd_b : rd_a;
    assign f_s    = sel ? f_b  : f_a;

    always #5 clk = ~clk;

    instr_mem_responder #(.WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(rst_n), .read(read_a), .address(address),
        .waitrequest(wr_a), .readdata(rd_a), .fault(f_a),
        .load_en(load_en), .load_index(load_index), .load_data(load_data)
    );

    instr_mem_responder #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(rst_n), .read(read_b), .address(address),
        .waitrequest(wr_b), .readdata(rd_b), .fault(f_b),
        .load_en(load_en), .load_index(load_index), .load_data(load_data)
    );

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: word offset from the base, wrapping; misaligned or beyond 256 words faults.
    function automatic logic [32:0] model(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00 || off / 4 >= 256) return {1'b1, 32'h0};
        return {1'b0, mem_m[off / 4]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && !wr_s) begin
            if (exp_q.size() == 0) begin
                chk("spurious_completion", 33'd1, 33'd0);
            end else if (read) begin
                chk("response", {f_s, rd_s}, exp_q.pop_front());
            end
        end
    end

    task automatic load(input int idx, input logic [31:0] data);
        @(negedge clk);
        load_en = 1'b1; load_index = 8'(idx); load_data = data;
        @(negedge clk);
        load_en = 1'b0;
        mem_m[idx] = data;
    endtask

    // Hold read until completion; optionally load on the DONE-entry edge of this fetch.
    task automatic fetch(input logic [31:0] a, input bit do_ld, input logic [7:0] li,
                         input logic [31:0] ld);
        int ws;
        int n;
        bit done;
        ws = sel ? 0 : 2;
        n = 0;
        done = 1'b0;
        @(negedge clk);
        address = a;
        read = 1'b1;
        exp_q.push_back(model(a));
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) address = $urandom;
            load_en = do_ld && (n == ws);
            load_index = li;
            load_data = ld;
            if (!wr_s) done = 1'b1;
        end
        load_en = 1'b0;
        chk("latency", 33'(n), 33'(ws + 1));
        if (do_ld) mem_m[li] = ld;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic abort_fetch(input logic [31:0] a);
        @(negedge clk);
        address = a;
        read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_idle_waitreq", {32'h0, wr_s}, 33'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; read = 1'b0; sel = 1'b0; address = 32'h0;
        load_en = 1'b0; load_index = 8'h0; load_data = 32'h0;
        #12;
        chk("reset_waitreq_a", {32'h0, wr_a}, 33'd1);
        chk("reset_readdata_a", {f_a, rd_a}, 33'h0);
        chk("reset_waitreq_b", {32'h0, wr_b}, 33'd1);
        chk("reset_readdata_b", {f_b, rd_b}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) load(i, $urandom);
        load(0, 32'h3C011234);

        fetch(BASE, 1'b0, 8'd0, 32'h0);
        fetch(32'h00000000, 1'b0, 8'd0, 32'h0);
        fetch(32'hBFC00002, 1'b0, 8'd0, 32'h0);
        fetch(32'hBFC003FC, 1'b0, 8'd0, 32'h0);
        fetch(32'hBFC00400, 1'b0, 8'd0, 32'h0);

        abort_fetch(32'hBFC00020);
        fetch(32'hBFC00010, 1'b0, 8'd0, 32'h0);

        // Asynchronous reset mid-WAIT clears outputs at once and drops the fetch.
        @(negedge clk);
        address = 32'hBFC00008;
        read = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_waitreq", {32'h0, wr_a}, 33'd1);
        chk("midwait_reset_readdata", {f_a, rd_a}, 33'h0);
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        fetch(BASE, 1'b0, 8'd0, 32'h0);

        fetch(32'hBFC00004, 1'b1, 8'd1, 32'hCAFEF00D);
        fetch(32'hBFC00004, 1'b0, 8'd0, 32'h0);

        sel = 1'b1;
        fetch(32'hBFC00004, 1'b0, 8'd0, 32'h0);
        fetch(32'hBFC00008, 1'b0, 8'd0, 32'h0);
        fetch(32'hBFC00000, 1'b0, 8'd0, 32'h0);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            int kind;
            sel = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 3);
            case (kind)
                0: a = BASE + 32'(4 * $urandom_range(0, 255));
                1: a = BASE + 32'($urandom_range(0, 1023));
                2: a = $urandom;
                default: a = BASE + 32'(4 * $urandom_range(250, 300));
            endcase
            if (!sel && $urandom_range(0, 7) == 0) begin
                abort_fetch(a);
            end else if (!sel && $urandom_range(0, 4) == 0) begin
                fetch(a, 1'b1, 8'((a - BASE) >> 2), $urandom);
            end else begin
                fetch(a, 1'b0, 8'd0, 32'h0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", 33'(exp_q.size()), 33'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
